// File: rtl/test_completion_monitor.sv
// End-of-test controller: per-channel pass/fail/hang tracking, global timeout, RUN->DRAIN->FINISH->DONE.
// Optional TCM_FAIL_FAST_EN: leave RUN on the first FAILED/HUNG channel instead of waiting for all.
module test_completion_monitor #(
    parameter int                    NUM_CH         = 1,
    parameter int                    CSR_ADDR_W     = 12,
    parameter logic [CSR_ADDR_W-1:0] STATUS_ADDR    = 12'h7C0,
    parameter logic [31:0]           PASS_CODE      = 32'h1,
    parameter logic [31:0]           FAIL_CODE      = 32'h2,
    parameter int                    CYC_W          = 20,
    parameter int                    TIMEOUT_CYCLES = 500000,
    parameter int                    HANG_CYCLES    = 4096,
    parameter int                    DRAIN_CYCLES   = 15
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic [NUM_CH-1:0]                         csr_we_i,
    input  logic [NUM_CH*CSR_ADDR_W-1:0]              csr_addr_i,
    input  logic [NUM_CH*32-1:0]                      csr_wdata_i,
    input  logic [NUM_CH-1:0]                         retire_i,
    output logic [NUM_CH*2-1:0]                       ch_status_o,
    output logic [1:0]                                state_o,
    output logic [CYC_W-1:0]                          cycle_cnt_o,
    output logic                                      timeout_o,
    output logic                                      pass_o,
    output logic                                      fail_o,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] fail_ch_o,
    output logic                                      finish_o
);

    localparam int FCW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HW  = $clog2(HANG_CYCLES + 1);
    localparam int DW  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [HW-1:0]    HANG_LIM    = HW'(HANG_CYCLES);
    localparam logic [CYC_W-1:0] TIMEOUT_VAL = CYC_W'(TIMEOUT_CYCLES);
    localparam logic [CYC_W-1:0] CYC_MAX     = '1;
    localparam logic [DW-1:0]    DRAIN_LOAD  = DW'(DRAIN_CYCLES - 1);

    localparam logic [1:0] CH_RUNNING = 2'b00;
    localparam logic [1:0] CH_PASSED  = 2'b01;
    localparam logic [1:0] CH_FAILED  = 2'b10;
    localparam logic [1:0] CH_HUNG    = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_FINISH = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        ch_status_q [NUM_CH];
    logic [1:0]        ch_status_d [NUM_CH];
    logic [HW-1:0]     idle_cnt_q  [NUM_CH];
    logic [HW-1:0]     idle_cnt_d  [NUM_CH];
    logic [CYC_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic              timeout_q, timeout_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              fail_capt_q, fail_capt_d;
    logic [FCW-1:0]    fail_ch_q, fail_ch_d;
    logic [DW-1:0]     drain_cnt_q, drain_cnt_d;

    logic              all_resolved;
    logic              any_failed;
    logic              all_passed;
    logic              new_fail;
    logic [FCW-1:0]    new_fail_idx;
    logic              exit_res;

    always_comb begin
        state_d      = state_q;
        ch_status_d  = ch_status_q;
        idle_cnt_d   = idle_cnt_q;
        cycle_cnt_d  = (cycle_cnt_q == CYC_MAX) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
        timeout_d    = timeout_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        fail_capt_d  = fail_capt_q;
        fail_ch_d    = fail_ch_q;
        drain_cnt_d  = drain_cnt_q;
        all_resolved = 1'b1;
        any_failed   = 1'b0;
        all_passed   = 1'b1;
        new_fail     = 1'b0;
        new_fail_idx = '0;
        exit_res     = 1'b0;

        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_status_q[i] != CH_PASSED) all_passed = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                // A CSR result on the same edge takes precedence over the hang watchdog
                for (int i = 0; i < NUM_CH; i++) begin
                    idle_cnt_d[i] = retire_i[i] ? '0
                                  : (ch_status_q[i] == CH_RUNNING) ? idle_cnt_q[i] + 1'b1
                                  : idle_cnt_q[i];
                    if (ch_status_q[i] == CH_RUNNING) begin
                        if (csr_we_i[i] && csr_addr_i[i*CSR_ADDR_W +: CSR_ADDR_W] == STATUS_ADDR
                            && csr_wdata_i[i*32 +: 32] == PASS_CODE)
                            ch_status_d[i] = CH_PASSED;
                        else if (csr_we_i[i] && csr_addr_i[i*CSR_ADDR_W +: CSR_ADDR_W] == STATUS_ADDR
                                 && csr_wdata_i[i*32 +: 32] == FAIL_CODE)
                            ch_status_d[i] = CH_FAILED;
                        else if (!retire_i[i] && idle_cnt_d[i] == HANG_LIM)
                            ch_status_d[i] = CH_HUNG;
                    end
                    if (ch_status_d[i] == CH_RUNNING) all_resolved = 1'b0;
                    if (ch_status_d[i][1]) any_failed = 1'b1;
                end

                // Descending scan leaves the lowest newly failed index
                for (int i = NUM_CH - 1; i >= 0; i--) begin
                    if (ch_status_d[i][1] && !ch_status_q[i][1]) begin
                        new_fail     = 1'b1;
                        new_fail_idx = FCW'(i);
                    end
                end
                if (new_fail && !fail_capt_q) begin
                    fail_capt_d = 1'b1;
                    fail_ch_d   = new_fail_idx;
                end

`ifdef TCM_FAIL_FAST_EN
                exit_res = all_resolved | any_failed;
`else
                exit_res = all_resolved;
`endif
                if (exit_res) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end else if (cycle_cnt_d == TIMEOUT_VAL) begin
                    timeout_d   = 1'b1;
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = ST_FINISH;
                    pass_d  = all_passed & ~timeout_q;
                    fail_d  = ~(all_passed & ~timeout_q);
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            ST_FINISH: state_d = ST_DONE;
            ST_DONE:   state_d = ST_DONE;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_RUN;
            cycle_cnt_q <= '0;
            timeout_q   <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_capt_q <= 1'b0;
            fail_ch_q   <= '0;
            drain_cnt_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_status_q[i] <= CH_RUNNING;
                idle_cnt_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            timeout_q   <= timeout_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            fail_capt_q <= fail_capt_d;
            fail_ch_q   <= fail_ch_d;
            drain_cnt_q <= drain_cnt_d;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_status_q[i] <= ch_status_d[i];
                idle_cnt_q[i]  <= idle_cnt_d[i];
            end
        end
    end

    always_comb begin
        ch_status_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_status_o[2*i +: 2] = ch_status_q[i];
        end
    end

    assign state_o     = state_q;
    assign cycle_cnt_o = cycle_cnt_q;
    assign timeout_o   = timeout_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign fail_ch_o   = fail_ch_q;
    assign finish_o    = (state_q == ST_FINISH);

endmodule
